// File: rtl/mux2_stream_arbiter.sv
// Two-input valid/ready arbiter feeding a one-entry output register and a 2:1 mux select.
// Latency: a beat accepted on edge N is presented on out_data/sel with out_valid in cycle N+1.
// Backpressure: a held beat with out_ready low drops both readies; accept and drain overlap otherwise.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a_data/a_valid/a_ready  source a stream (sel code 0)
//   b_data/b_valid/b_ready  source b stream (sel code 1)
//   out_data/out_valid/out_ready  registered output stream
//   sel                   registered source code of the held beat, drives the downstream mux
//   cnt_a, cnt_b          free-running, wrapping counts of accepted beats per source
//
// Build option: define MUX2_ARB_FIXED_PRIO_EN for fixed priority (a over b);
// the default build is round-robin.
module mux2_stream_arbiter #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [WIDTH-1:0]     b_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel,
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b
);

    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sel_q,       sel_d;
    logic                 last_q,      last_d;
    logic [CNT_WIDTH-1:0] cnt_a_q,     cnt_a_d;
    logic [CNT_WIDTH-1:0] cnt_b_q,     cnt_b_d;

    logic load;
    logic grant_a;
    logic grant_b;
    logic acc_a;
    logic acc_b;

    always_comb begin
        load = !out_valid_q || out_ready;
`ifdef MUX2_ARB_FIXED_PRIO_EN
        grant_a = a_valid;
        grant_b = b_valid && !a_valid;
`else
        // last_q==1 means b was granted most recently, so a wins a tie.
        grant_a = a_valid && (!b_valid || last_q);
        grant_b = b_valid && (!a_valid || !last_q);
`endif
        // Readies are forced low while reset is held so no source sees a
        // handshake that the cleared registers will never record.
        acc_a = rst_n && load && grant_a;
        acc_b = rst_n && load && grant_b;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        if (load) begin
            // With nothing to load the register empties but keeps data/sel.
            out_valid_d = acc_a || acc_b;
            if (acc_a) begin
                out_data_d = a_data;
                sel_d      = 1'b0;
                last_d     = 1'b0;
                cnt_a_d    = cnt_a_q + 1'b1;
            end else if (acc_b) begin
                out_data_d = b_data;
                sel_d      = 1'b1;
                last_d     = 1'b1;
                cnt_b_d    = cnt_b_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
        end
    end

    assign a_ready   = acc_a;
    assign b_ready   = acc_b;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel       = sel_q;
    assign cnt_a     = cnt_a_q;
    assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
module tb_mux2_stream_arbiter;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  a_data, b_data, out_data;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic          out_valid, out_ready, sel;
    logic [CW-1:0] cnt_a, cnt_b;
    logic [W-1:0]  mux_y;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic          m_last;
    logic          m_ov;
    logic [CW-1:0] m_cnt_a, m_cnt_b;
    logic          m_acc_a, m_acc_b;
    logic [W:0]    sb_q[$];   // {sel, data} of beats expected on the output

    always #5 clk = ~clk;

    mux2_stream_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    // Downstream 2:1 mux: input a = out_data, input b = ~out_data.
    assign mux_y = sel ? ~out_data : out_data;

    task automatic model_reset();
        m_last  = 1'b1;
        m_ov    = 1'b0;
        m_cnt_a = '0;
        m_cnt_b = '0;
        m_acc_a = 1'b0;
        m_acc_b = 1'b0;
        sb_q.delete();
    endtask

    // One clock of scoreboarded operation: check at the falling edge, advance
    // the model, then return just after the rising edge.
    task automatic clock_and_score();
        logic ld, ga, gb, ea, eb;
        logic [W:0] hd;
        @(negedge clk);
        ld = !m_ov || out_ready;
`ifdef MUX2_ARB_FIXED_PRIO_EN
        ga = a_valid;
        gb = b_valid && !a_valid;
`else
        ga = a_valid && (!b_valid || m_last);
        gb = b_valid && (!a_valid || !m_last);
`endif
        ea = ld && ga;
        eb = ld && gb;
        vectors++;
        if (a_ready !== ea) begin miscompares++; $display("FAIL a_ready: got %b want %b", a_ready, ea); end
        vectors++;
        if (b_ready !== eb) begin miscompares++; $display("FAIL b_ready: got %b want %b", b_ready, eb); end
        vectors++;
        if (out_valid !== m_ov) begin miscompares++; $display("FAIL out_valid: got %b want %b", out_valid, m_ov); end
        vectors++;
        if (cnt_a !== m_cnt_a) begin miscompares++; $display("FAIL cnt_a: got %0d want %0d", cnt_a, m_cnt_a); end
        vectors++;
        if (cnt_b !== m_cnt_b) begin miscompares++; $display("FAIL cnt_b: got %0d want %0d", cnt_b, m_cnt_b); end
        if (m_ov) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++; $display("FAIL scoreboard: got empty queue want held beat");
            end else begin
                hd = sb_q[0];
                if (out_data !== hd[W-1:0]) begin
                    miscompares++; $display("FAIL out_data: got %h want %h", out_data, hd[W-1:0]);
                end
                vectors++;
                if (sel !== hd[W]) begin miscompares++; $display("FAIL sel: got %b want %b", sel, hd[W]); end
                vectors++;
                if (mux_y !== (hd[W] ? ~hd[W-1:0] : hd[W-1:0])) begin
                    miscompares++; $display("FAIL mux_out: got %h want %h", mux_y, hd[W] ? ~hd[W-1:0] : hd[W-1:0]);
                end
                if (out_ready) sb_q.delete(0);
            end
        end
        m_acc_a = ea;
        m_acc_b = eb;
        if (ld) begin
            if (ea) begin sb_q.push_back({1'b0, a_data}); m_last = 1'b0; m_cnt_a++; end
            else if (eb) begin sb_q.push_back({1'b1, b_data}); m_last = 1'b1; m_cnt_b++; end
            m_ov = ea || eb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        a_data = 8'h5A; b_data = 8'hA5; out_ready = 1'b1;
        #3;
        vectors++;
        if ({out_valid, sel, out_data, cnt_a, cnt_b} !== '0) begin
            miscompares++; $display("FAIL reset_state: got v%b s%b d%h ca%0d cb%0d want all zero", out_valid, sel, out_data, cnt_a, cnt_b);
        end
        vectors++;
        if ({a_ready, b_ready} !== 2'b00) begin
            miscompares++; $display("FAIL ready_in_reset: got %b%b want 00", a_ready, b_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        model_reset();
        clock_and_score();
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b0; out_ready = 1'b1;
        clock_and_score();
        a_valid = 1'b0;
        vectors++;
        if ({out_valid, sel, out_data, cnt_a} !== {1'b1, 1'b0, 8'h11, 4'd1}) begin
            miscompares++; $display("FAIL single_beat: got v%b s%b d%h ca%0d want v1 s0 d11 ca1", out_valid, sel, out_data, cnt_a);
        end
        clock_and_score();
        clock_and_score();
    endtask

    task automatic test_alternate();
        logic [3:0] seen, want;
        int na = 0, nb = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_data = 8'hA0 + 8'(na); b_data = 8'hB0 + 8'(nb);
            clock_and_score();
            if (m_acc_a) na++;
            if (m_acc_b) nb++;
            seen[i] = sel;
        end
        a_valid = 1'b0; b_valid = 1'b0;
`ifdef MUX2_ARB_FIXED_PRIO_EN
        want = 4'b0000;
        vectors++;
        if ({cnt_a, cnt_b} !== {4'd4, 4'd0}) begin
            miscompares++; $display("FAIL alt_counts: got a%0d b%0d want a4 b0", cnt_a, cnt_b);
        end
`else
        want = 4'b1010;   // beat i in bit i: a, b, a, b
        vectors++;
        if ({cnt_a, cnt_b} !== {4'd2, 4'd2}) begin
            miscompares++; $display("FAIL alt_counts: got a%0d b%0d want a2 b2", cnt_a, cnt_b);
        end
`endif
        vectors++;
        if (seen !== want) begin miscompares++; $display("FAIL alt_sel_seq: got %b want %b", seen, want); end
        clock_and_score();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] nxt;
        out_ready = 1'b1; a_valid = 1'b1; a_data = 8'h33; b_valid = 1'b0;
        clock_and_score();
        out_ready = 1'b0; a_data = 8'h44; b_valid = 1'b1; b_data = 8'h55;
        repeat (3) clock_and_score();
        vectors++;
        if ({out_valid, sel, out_data} !== {1'b1, 1'b0, 8'h33}) begin
            miscompares++; $display("FAIL stall_hold: got v%b s%b d%h want v1 s0 d33", out_valid, sel, out_data);
        end
        out_ready = 1'b1;
        clock_and_score();   // held 0x33 drains while the next beat loads
`ifdef MUX2_ARB_FIXED_PRIO_EN
        nxt = 8'h44;
        a_valid = 1'b0;
`else
        nxt = 8'h55;
        b_valid = 1'b0;
`endif
        vectors++;
        if ({out_valid, out_data} !== {1'b1, nxt}) begin
            miscompares++; $display("FAIL drain_and_load: got v%b d%h want v1 d%h", out_valid, out_data, nxt);
        end
        clock_and_score();
        a_valid = 1'b0; b_valid = 1'b0;
        clock_and_score();
        clock_and_score();
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_valid = 1'b1; b_data = 8'(i);
            clock_and_score();
        end
        b_valid = 1'b0;
        vectors++;
        if (cnt_b !== 4'd0) begin miscompares++; $display("FAIL cnt_b_wrap: got %0d want 0", cnt_b); end
        clock_and_score();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1; b_valid = 1'b1; b_data = 8'hC3; a_valid = 1'b0;
        clock_and_score();
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, sel, out_data, cnt_a, cnt_b} !== '0) begin
            miscompares++; $display("FAIL async_reset: got v%b s%b d%h ca%0d cb%0d want all zero", out_valid, sel, out_data, cnt_a, cnt_b);
        end
        vectors++;
        if (b_ready !== 1'b0) begin miscompares++; $display("FAIL ready_mid_reset: got %b want 0", b_ready); end
        model_reset();
        #1;
        rst_n = 1'b1;
        a_valid = 1'b1; a_data = 8'h66; out_ready = 1'b1;
        clock_and_score();
        a_valid = 1'b0; b_valid = 1'b0;
        vectors++;
        if ({sel, out_data} !== {1'b0, 8'h66}) begin
            miscompares++; $display("FAIL tie_after_reset: got s%b d%h want s0 d66", sel, out_data);
        end
        clock_and_score();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux2_stream_arbiter.md
# mux2_stream_arbiter

Two-input valid/ready arbiter that sits directly upstream of `mux_2to1`. It picks one of two requesting sources each cycle, captures the winning beat into a one-entry output register, and drives the select line of the downstream 2-to-1 mux with the matching code: `sel=0` selects source a, `sel=1` selects source b. It also counts the beats accepted per source for debug visibility.

## Interface
- `WIDTH`, 8, data width of each source and of the output.
- `CNT_WIDTH`, 16, width of each per-source beat counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a_data`  input  WIDTH  source a payload.
- `a_valid`  input  1  source a has a beat.
- `a_ready`  output  1  source a beat accepted this cycle when high together with `a_valid`.
- `b_data`  input  WIDTH  source b payload.
- `b_valid`  input  1  source b has a beat.
- `b_ready`  output  1  source b beat accepted this cycle when high together with `b_valid`.
- `out_data`  output  WIDTH  registered winning payload.
- `out_valid`  output  1  output register holds a beat.
- `out_ready`  input  1  downstream accepts the beat.
- `sel`  output  1  registered source of the held beat: 0 = a, 1 = b. Drives the mux select.
- `cnt_a`  output  CNT_WIDTH  count of accepted a beats.
- `cnt_b`  output  CNT_WIDTH  count of accepted b beats.

## Operation
- `load = !out_valid || out_ready`: the register is empty or is draining this cycle.
- Round-robin pointer `last`: 1 bit, holding the last source granted.
- Grant rules (combinational):
  - `grant_a = a_valid && (!b_valid || last==1)`.
  - `grant_b = b_valid && (!a_valid || last==0)`.
  - Exactly one grant is active when any source is valid.
- Ready outputs: `a_ready = load && grant_a`, `b_ready = load && grant_b`. Ready never rises for a non-requesting source.
- On accept of source a:
  - `out_data <= a_data`, `sel <= 0`, `out_valid <= 1`.
  - `last <= 0`.
  - `cnt_a` increments.
- On accept of source b: the same actions mirrored (`sel <= 1`, `last <= 1`, `cnt_b` increments).
- `load` high with no valid source: `out_valid <= 0`. `out_data` and `sel` hold their last values.
- `out_valid` high and `out_ready` low: `out_data`, `sel` and `out_valid` are stable, and `a_ready`/`b_ready` are 0.
- Counters wrap from 2^CNT_WIDTH-1 to 0 with no saturation and no flag.
- Reset values: `out_valid=0`, `out_data=0`, `sel=0`, `last=1` (a wins the first tie), `cnt_a=0`, `cnt_b=0`.

## Timing
- Latency: a beat accepted in cycle N appears on `out_data`/`sel` with `out_valid` high in cycle N+1.
- Throughput: one beat per cycle when `out_ready` stays high. Accept and drain happen in the same cycle.
- `sel` changes only on the edge where a new beat loads, so it is always aligned with `out_data`.
- Simultaneous `a_valid` and `b_valid` every cycle: grants alternate a, b, a, b, …
- Source sources must hold `data`/`valid` until accepted. The arbiter may legally re-grant the other source while a waiting source is not selected.
- Reset asserted mid-operation:
  - All registers clear immediately (asynchronously).
  - Any held beat is dropped.
  - `a_ready`/`b_ready` read 0 while `rst_n` is low.
- Reset deassertion takes effect at the next rising edge of `clk`.

## Configuration
- `MUX2_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. `grant_a = a_valid`, `grant_b = b_valid && !a_valid`. `last` is still tracked but is not used for grants.
  - Undefined (default): round-robin as described above.
- Ports, latency and reset behaviour are identical in both builds.

## Test plan
- Reset, then `a_valid=1`, `a_data=0x11`, `b_valid=0`, `out_ready=1` → next cycle `out_data=0x11`, `sel=0`, `out_valid=1`, `cnt_a=1`.
- Both valid for 4 cycles (a=0xA0.., b=0xB0..), `out_ready=1` → outputs alternate a, b, a, b with `sel` 0, 1, 0, 1; `cnt_a=2`, `cnt_b=2`. With `MUX2_ARB_FIXED_PRIO_EN` defined: four a beats, `sel=0` throughout, `b_ready=0` throughout.
- Hold `out_ready=0` for 3 cycles with a beat held → `out_data`/`sel` stable, `a_ready=b_ready=0`. Raise `out_ready` → the next beat loads in the same cycle the held beat drains.
- Preload `cnt_b` near wrap with 2^CNT_WIDTH accepted b beats (`CNT_WIDTH=4`: 16 beats) → `cnt_b` returns to 0.
- Assert `rst_n=0` mid-stream while `out_valid=1` → `out_valid`, `sel`, `out_data` and the counters are 0 immediately, before the next `clk` edge. After release, the first tie goes to a.
- Connect `out_data`/`sel` to `mux_2to1` (a=`out_data`, b=~`out_data`) → mux output equals `out_data` when `sel=0` and ~`out_data` when `sel=1`.
